ram_input_sequencer: RTL and testbench
======================================

Name: ram_input_sequencer

Overview:
- Controller for the 1-bit × 1024-entry input-vector RAM, which has a registered read address (read latency 1 cycle).
- Arbitrates the RAM's single address port between two requesters:
  - a serial loader that writes a new input vector;
  - the hidden-layer compute stage, which reads the full vector once per hidden neuron (NUM_PASSES times, back to back).
- Sits between the input loader, the RAM and the hidden-unit MAC array.

Parameters:
- ADDR_W, 10, RAM address width.
- NUM_INPUTS, 784, vector length in bits. Legal range 1..2**ADDR_W.
- NUM_PASSES, 32, full-vector reads per compute request. Legal range 1..256.

Ports:
- clk, in, 1, clock; all logic on posedge.
- rst, in, 1, asynchronous, active-high reset.
- load_start, in, 1, request to load a new vector.
- load_valid, in, 1, load_data is valid.
- load_data, in, 1, input bit to write.
- load_ready, out, 1, sequencer accepts a load beat.
- load_done, out, 1, one-cycle pulse: vector fully written.
- comp_start, in, 1, request a compute sweep.
- ram_addr, out, ADDR_W, RAM address.
- ram_we, out, 1, RAM write enable.
- ram_data, out, 1, RAM write data.
- ram_q, in, 1, RAM read data; reflects the address of the previous cycle.
- in_bit, out, 1, streamed input bit to the hidden units.
- in_valid, out, 1, in_bit is valid.
- in_last, out, 1, marks the last bit of a pass.
- pass_idx, out, 8, index of the pass owning in_bit.
- comp_done, out, 1, one-cycle pulse coincident with the final in_valid.
- busy, out, 1, state is not IDLE.
- load_popcount, out, ADDR_W+1, see Optional Feature.

Behaviour:

Reset:
- state = IDLE; wr_ptr, rd_ptr, pass counter and comp_pending are cleared.
- All outputs are 0 after reset.
- RAM contents are untouched.
- Reset asserted mid-LOAD or mid-READ aborts immediately. No done pulse is produced.

States:
- IDLE:
  - load_start → LOAD.
  - Otherwise, comp_start or comp_pending → READ, and comp_pending is cleared.
  - load_start and comp_start in the same cycle: LOAD wins and comp_pending is set.
- LOAD:
  - load_ready = 1.
  - A beat completes on load_valid & load_ready. In that cycle: ram_we = 1, ram_addr = wr_ptr, ram_data = load_data, then wr_ptr++.
  - Gaps (load_valid = 0) are allowed; ram_we = 0 during a gap.
  - The beat with wr_ptr == NUM_INPUTS-1 → state DONE_L and wr_ptr is cleared.
- DONE_L:
  - load_done = 1 for one cycle (the cycle after the last write) → IDLE.
- READ:
  - ram_addr = rd_ptr and ram_we = 0 on every cycle; there are no bubbles.
  - rd_ptr wraps NUM_INPUTS-1 → 0 and the pass counter increments.
  - After issuing address NUM_INPUTS-1 of pass NUM_PASSES-1 → DRAIN.
- DRAIN:
  - One cycle that delivers the final bit → IDLE.

Read pipeline:
- In the cycle after address a of pass p is issued: in_valid = 1, in_bit = ram_q, pass_idx = p, and in_last = (a == NUM_INPUTS-1).
- comp_done = 1 with the final in_last of pass NUM_PASSES-1.
- Latency: comp_start accepted in IDLE at cycle t → first in_valid at t+2 → last in_valid at t+1+NUM_INPUTS*NUM_PASSES.

Arbitration:
- comp_start received while state ≠ IDLE sets comp_pending. Multiple requests coalesce into one.
- load_start is ignored unless the state is IDLE.
- The compute stage therefore never observes a partially loaded vector.

Idle outputs:
- ram_addr = 0, ram_we = 0, ram_data = 0.
- in_valid = 0, in_last = 0, in_bit = 0.

Optional Feature:
- Macro: RAM_SEQ_POPCOUNT_EN.
- Defined:
  - load_popcount counts the 1-bits written during LOAD.
  - It is cleared on entry to LOAD and holds its final value from the load_done cycle until the next LOAD.
  - Range 0..NUM_INPUTS.
- Undefined:
  - No counter logic.
  - load_popcount is tied to 0.

Test Plan:
- NUM_INPUTS=8, NUM_PASSES=2. Load 8'b1011_0010 (LSB first), with load_valid dropped for 2 cycles mid-vector → 8 writes at addresses 0..7, ram_we only on accepted beats, load_done one cycle after the addr-7 write, popcount = 4 when RAM_SEQ_POPCOUNT_EN is defined.
- After that load, comp_start at cycle t → in_valid asserted for cycles t+2..t+17, bits 0,1,0,0,1,1,0,1 twice, in_last at t+9 and t+17, pass_idx 0 then 1, comp_done at t+17, busy low at t+18.
- load_start and comp_start in the same IDLE cycle → load completes first; READ starts the cycle after load_done returns to IDLE, with no extra comp_start.
- comp_start pulsed 3 times during READ → exactly one additional sweep follows.
- rst asserted mid-READ on pass 1 → next cycle: in_valid = 0, busy = 0, comp_done never pulses; a new comp_start restarts from address 0, pass 0.
- NUM_INPUTS=1024, NUM_PASSES=1 → rd_ptr wraps at 1023 without overflow and exactly 1024 in_valid beats are produced.

Source files
------------

// File: rtl/ram_input_sequencer_if.sv
// Bus bundle between the input sequencer and its peers: loader handshake, RAM port
// and the bit stream toward the hidden-unit MAC array.
interface ram_input_sequencer_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              load_start;
    logic              load_valid;
    logic              load_data;
    logic              load_ready;
    logic              load_done;
    logic              comp_start;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic              ram_data;
    logic              ram_q;
    logic              in_bit;
    logic              in_valid;
    logic              in_last;
    logic [7:0]        pass_idx;
    logic              comp_done;
    logic              busy;
    logic [ADDR_W:0]   load_popcount;

    // Sequencer side.
    modport master (
        input  load_start, load_valid, load_data, comp_start, ram_q,
        output load_ready, load_done, ram_addr, ram_we, ram_data,
               in_bit, in_valid, in_last, pass_idx, comp_done, busy, load_popcount
    );

    // Loader / RAM / MAC-array side.
    modport slave (
        output load_start, load_valid, load_data, comp_start, ram_q,
        input  load_ready, load_done, ram_addr, ram_we, ram_data,
               in_bit, in_valid, in_last, pass_idx, comp_done, busy, load_popcount
    );
endinterface

// File: rtl/ram_input_sequencer.sv
// Arbitrates the single address port of the 1-bit input-vector RAM between a serial loader
// and repeated full-vector compute sweeps. Define RAM_SEQ_POPCOUNT_EN to count loaded 1-bits.
module ram_input_sequencer #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned NUM_INPUTS = 784,
    parameter int unsigned NUM_PASSES = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    ram_input_sequencer_if.master      bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StDoneL, StRead, StDrain} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_INPUTS - 1);
    localparam logic [7:0]        LastPass = 8'(NUM_PASSES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]        pass_q, pass_d;
    logic              comp_pending_q, comp_pending_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              rd_final_q, rd_final_d;
    logic [7:0]        rd_pass_q, rd_pass_d;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        pass_d         = pass_q;
        comp_pending_d = comp_pending_q;
        rd_valid_d     = 1'b0;
        rd_last_d      = 1'b0;
        rd_final_d     = 1'b0;
        rd_pass_d      = 8'd0;
        bus.ram_addr   = '0;
        bus.ram_we     = 1'b0;
        bus.ram_data   = 1'b0;
        bus.load_ready = 1'b0;
        bus.load_done  = 1'b0;

        // Requests arriving while busy coalesce into a single deferred sweep.
        if (bus.comp_start && state_q != StIdle) begin
            comp_pending_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (bus.load_start) begin
                    state_d  = StLoad;
                    wr_ptr_d = '0;
                    if (bus.comp_start) begin
                        comp_pending_d = 1'b1;
                    end
                end else if (bus.comp_start || comp_pending_q) begin
                    state_d        = StRead;
                    rd_ptr_d       = '0;
                    pass_d         = 8'd0;
                    comp_pending_d = 1'b0;
                end
            end
            StLoad: begin
                bus.load_ready = 1'b1;
                bus.ram_addr   = wr_ptr_q;
                if (bus.load_valid) begin
                    bus.ram_we   = 1'b1;
                    bus.ram_data = bus.load_data;
                    if (wr_ptr_q == LastAddr) begin
                        wr_ptr_d = '0;
                        state_d  = StDoneL;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            StDoneL: begin
                bus.load_done = 1'b1;
                state_d       = StIdle;
            end
            StRead: begin
                bus.ram_addr = rd_ptr_q;
                rd_valid_d   = 1'b1;
                rd_pass_d    = pass_q;
                rd_last_d    = (rd_ptr_q == LastAddr);
                rd_final_d   = rd_last_d && (pass_q == LastPass);
                if (rd_ptr_q == LastAddr) begin
                    rd_ptr_d = '0;
                    if (pass_q == LastPass) begin
                        pass_d  = 8'd0;
                        state_d = StDrain;
                    end else begin
                        pass_d = pass_q + 8'd1;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            StDrain: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            pass_q         <= 8'd0;
            comp_pending_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            rd_final_q     <= 1'b0;
            rd_pass_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            pass_q         <= pass_d;
            comp_pending_q <= comp_pending_d;
            rd_valid_q     <= rd_valid_d;
            rd_last_q      <= rd_last_d;
            rd_final_q     <= rd_final_d;
            rd_pass_q      <= rd_pass_d;
        end
    end

    // The RAM answers one cycle after the address, so stream flags ride a matching register.
    assign bus.in_valid  = rd_valid_q;
    assign bus.in_bit    = rd_valid_q & bus.ram_q;
    assign bus.in_last   = rd_last_q;
    assign bus.comp_done = rd_final_q;
    assign bus.pass_idx  = rd_pass_q;
    assign bus.busy      = (state_q != StIdle);

`ifdef RAM_SEQ_POPCOUNT_EN
    logic [ADDR_W:0] pop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_q <= '0;
        end else if (state_q == StIdle && bus.load_start) begin
            pop_q <= '0;
        end else if (state_q == StLoad && bus.load_valid && bus.load_data) begin
            pop_q <= pop_q + (ADDR_W + 1)'(1);
        end
    end

    assign bus.load_popcount = pop_q;
`else
    assign bus.load_popcount = '0;
`endif
endmodule

// File: tb/tb_ram_input_sequencer.sv
// Scoreboard bench: stimulus pushes expected writes, done pulses and stream beats into queues;
// negedge monitors pop and compare whenever the sequencers present an output.
module tb_ram_input_sequencer;
    typedef struct {
        int         cyc;
        logic       bitv;
        logic       last;
        logic [7:0] pass;
        logic       done;
    } sitem_t;

    typedef struct {
        int         cyc;
        logic [9:0] addr;
        logic       data;
    } witem_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   exp_pop = 0;

    sitem_t sq_a[$];
    sitem_t sq_b[$];
    witem_t wq[$];
    int     dq[$];
    sitem_t it_a, it_b;
    witem_t wi;
    int     di;

    logic mem_a [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_input_sequencer_if #(.ADDR_W(10)) a_if ();
    ram_input_sequencer_if #(.ADDR_W(10)) b_if ();

    ram_input_sequencer #(.ADDR_W(10), .NUM_INPUTS(8), .NUM_PASSES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.master)
    );

    ram_input_sequencer #(.ADDR_W(10), .NUM_INPUTS(1024), .NUM_PASSES(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.master)
    );

    function automatic logic pat_b(input logic [9:0] a);
        return a[0] ^ a[4] ^ a[9];
    endfunction

    // RAM models: registered read address, one-cycle latency.
    always @(posedge clk) begin
        if (a_if.ram_we) mem_a[a_if.ram_addr] <= a_if.ram_data;
        a_if.ram_q <= mem_a[a_if.ram_addr];
        b_if.ram_q <= pat_b(b_if.ram_addr);
    end

    function automatic void check(input string name, input int unsigned act,
                                  input int unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (a_if.in_valid) begin
                if (sq_a.size() == 0) begin
                    check("a unexpected in_valid", 1, 0);
                end else begin
                    it_a = sq_a.pop_front();
                    check("a stream cycle", cyc, it_a.cyc);
                    check("a in_bit", a_if.in_bit, it_a.bitv);
                    check("a in_last", a_if.in_last, it_a.last);
                    check("a pass_idx", a_if.pass_idx, it_a.pass);
                    check("a comp_done", a_if.comp_done, it_a.done);
                end
            end else if (a_if.in_last || a_if.comp_done || a_if.in_bit) begin
                check("a stray stream flags", 1, 0);
            end
            if (a_if.ram_we) begin
                if (wq.size() == 0) begin
                    check("a unexpected ram_we", 1, 0);
                end else begin
                    wi = wq.pop_front();
                    check("a write cycle", cyc, wi.cyc);
                    check("a write addr", a_if.ram_addr, wi.addr);
                    check("a write data", a_if.ram_data, wi.data);
                end
            end
            if (a_if.load_done) begin
                if (dq.size() == 0) begin
                    check("a unexpected load_done", 1, 0);
                end else begin
                    di = dq.pop_front();
                    check("a load_done cycle", cyc, di);
                    check("a load_popcount", a_if.load_popcount, exp_pop);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_if.in_valid) begin
                if (sq_b.size() == 0) begin
                    check("b unexpected in_valid", 1, 0);
                end else begin
                    it_b = sq_b.pop_front();
                    check("b stream cycle", cyc, it_b.cyc);
                    check("b in_bit", b_if.in_bit, it_b.bitv);
                    check("b in_last", b_if.in_last, it_b.last);
                    check("b pass_idx", b_if.pass_idx, it_b.pass);
                    check("b comp_done", b_if.comp_done, it_b.done);
                end
            end else if (b_if.in_last || b_if.comp_done) begin
                check("b stray stream flags", 1, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while ((sq_a.size() + sq_b.size() + wq.size() + dq.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, sq_a.size() + sq_b.size() + wq.size() + dq.size(), 0);
    endtask

    // Expected stream for a sweep accepted in IDLE at cycle acc on dut_a.
    task automatic push_sweep_a(input int acc, input logic [7:0] v);
        sitem_t s;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 8; a++) begin
                s.cyc  = acc + 2 + p * 8 + a;
                s.bitv = v[a];
                s.last = (a == 7);
                s.pass = 8'(p);
                s.done = (a == 7) && (p == 1);
                sq_a.push_back(s);
            end
        end
    endtask

    task automatic load_vec(input logic [7:0] v, input int gap_at, input logic with_comp,
                            output int last_cyc);
        witem_t w;
        a_if.load_start = 1'b1;
        a_if.comp_start = with_comp;
        tick();
        a_if.load_start = 1'b0;
        a_if.comp_start = 1'b0;
`ifdef RAM_SEQ_POPCOUNT_EN
        exp_pop = $countones(v);
`else
        exp_pop = 0;
`endif
        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                a_if.load_valid = 1'b0;
                tick();
                tick();
            end
            a_if.load_valid = 1'b1;
            a_if.load_data  = v[k];
            w.cyc  = cyc;
            w.addr = 10'(k);
            w.data = v[k];
            wq.push_back(w);
            if (k == 7) begin
                dq.push_back(cyc + 1);
                last_cyc = cyc;
            end
            #1;
            check("load_ready during beat", a_if.load_ready, 1);
            tick();
        end
        a_if.load_valid = 1'b0;
        a_if.load_data  = 1'b0;
    endtask

    initial begin
        int         t;
        int         c;
        sitem_t     s;
        logic [7:0] v1;
        logic [7:0] v2;
        v1  = 8'b1011_0010;
        v2  = 8'b0110_1100;
        rst = 1'b1;
        a_if.load_start = 1'b0;
        a_if.load_valid = 1'b0;
        a_if.load_data  = 1'b0;
        a_if.comp_start = 1'b0;
        b_if.load_start = 1'b0;
        b_if.load_valid = 1'b0;
        b_if.load_data  = 1'b0;
        b_if.comp_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", a_if.busy, 0);
        check("reset in_valid", a_if.in_valid, 0);
        check("reset ram_we", a_if.ram_we, 0);
        check("reset ram_addr", a_if.ram_addr, 0);
        check("reset load_ready", a_if.load_ready, 0);
        check("reset load_done", a_if.load_done, 0);
        check("reset comp_done", a_if.comp_done, 0);
        check("reset load_popcount", a_if.load_popcount, 0);
        rst = 1'b0;
        tick();

        // Load with a two-cycle gap before beat 4.
        load_vec(v1, 4, 1'b0, c);
        wait_empty("load 1 drained", 20);
        check("idle after load", a_if.busy, 0);

        // Single sweep, latency and busy timing.
        t = cyc;
        a_if.comp_start = 1'b1;
        push_sweep_a(t, v1);
        tick();
        a_if.comp_start = 1'b0;
        repeat (16) tick();
        check("busy in drain", a_if.busy, 1);
        tick();
        check("busy low after sweep", a_if.busy, 0);
        wait_empty("sweep 1 drained", 10);

        // load_start and comp_start together: load first, then the deferred sweep.
        load_vec(v2, 99, 1'b1, c);
        push_sweep_a(c + 2, v2);
        wait_empty("deferred sweep drained", 40);
        repeat (10) tick();

        // Three requests during READ coalesce into one extra sweep.
        t = cyc;
        a_if.comp_start = 1'b1;
        push_sweep_a(t, v2);
        push_sweep_a(t + 18, v2);
        tick();
        a_if.comp_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            a_if.comp_start = 1'b1;
            tick();
            a_if.comp_start = 1'b0;
            tick();
        end
        wait_empty("coalesced sweeps drained", 60);
        repeat (30) tick();
        check("idle after coalesced sweeps", a_if.busy, 0);

        // Reset in the middle of pass 1.
        t = cyc;
        a_if.comp_start = 1'b1;
        push_sweep_a(t, v2);
        tick();
        a_if.comp_start = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        sq_a.delete();
        #1;
        check("reset mid-read in_valid", a_if.in_valid, 0);
        check("reset mid-read busy", a_if.busy, 0);
        tick();
        rst = 1'b0;
        #1;
        check("after reset in_valid", a_if.in_valid, 0);
        check("after reset busy", a_if.busy, 0);
        repeat (20) tick();
        t = cyc;
        a_if.comp_start = 1'b1;
        push_sweep_a(t, v2);
        tick();
        a_if.comp_start = 1'b0;
        wait_empty("restart sweep drained", 40);

        // 1024 x 1 instance: address wrap at 1023 and exactly 1024 beats.
        t = cyc;
        b_if.comp_start = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            s.cyc  = t + 2 + a;
            s.bitv = pat_b(10'(a));
            s.last = (a == 1023);
            s.pass = 8'd0;
            s.done = (a == 1023);
            sq_b.push_back(s);
        end
        tick();
        b_if.comp_start = 1'b0;
        wait_empty("b sweep drained", 1100);
        repeat (10) tick();
        check("b idle after sweep", b_if.busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
